// File: rtl/pspin_egress_dma.sv
// pspin_egress_dma
// Egress DMA: takes one packet descriptor (PsPIN L2 address, length, tag) at a
// time. It reads the packet from PsPIN packet memory over an AXI4 read master,
// splitting bursts at 4 KiB boundaries. It forwards the read data with zero
// latency as one AXI-Stream frame to the NIC TX path, then returns one
// completion carrying the tag and a status.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   desc_*                 descriptor input (valid/ready)
//   m_axi_pspin_ar*        AXI4 read address channel (master)
//   m_axi_pspin_r*         AXI4 read data channel (master)
//   m_axis_nic_tx_*        AXI-Stream frame output
//   cpl_*                  completion output (valid/ready), status 0 OK,
//                          1 bad descriptor, 2 AXI read error
//
// Optional: defining PSPIN_EGRESS_DMA_STATS_EN adds the stat_pkts, stat_bytes
// and stat_errs counters.
//
// state | meaning
// IDLE  | waiting for a descriptor, desc_ready high
// AR    | presenting one burst request on the AR channel
// DATA  | streaming R beats of the current burst to the NIC
// CPL   | presenting the completion until it is accepted
module pspin_egress_dma #(
    parameter int AXIS_IF_DATA_WIDTH = 512,
    parameter int AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH/8,
    parameter int AXI_DATA_WIDTH     = 512,
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH       = 8,
    parameter int LEN_WIDTH          = 32,
    parameter int TAG_WIDTH          = 64,
    parameter int EGRESS_DMA_MTU     = 1500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXI_ADDR_WIDTH-1:0]     desc_addr,
    input  logic [LEN_WIDTH-1:0]          desc_len,
    input  logic [TAG_WIDTH-1:0]          desc_tag,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_arid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_pspin_araddr,
    output logic [7:0]                    m_axi_pspin_arlen,
    output logic [2:0]                    m_axi_pspin_arsize,
    output logic [1:0]                    m_axi_pspin_arburst,
    output logic                          m_axi_pspin_arlock,
    output logic [3:0]                    m_axi_pspin_arcache,
    output logic [2:0]                    m_axi_pspin_arprot,
    output logic                          m_axi_pspin_arvalid,
    input  logic                          m_axi_pspin_arready,
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_rid,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_pspin_rdata,
    input  logic [1:0]                    m_axi_pspin_rresp,
    input  logic                          m_axi_pspin_rlast,
    input  logic                          m_axi_pspin_rvalid,
    output logic                          m_axi_pspin_rready,
    output logic [AXIS_IF_DATA_WIDTH-1:0] m_axis_nic_tx_tdata,
    output logic [AXIS_IF_KEEP_WIDTH-1:0] m_axis_nic_tx_tkeep,
    output logic                          m_axis_nic_tx_tvalid,
    input  logic                          m_axis_nic_tx_tready,
    output logic                          m_axis_nic_tx_tlast,
    output logic [TAG_WIDTH-1:0]          cpl_tag,
    output logic [1:0]                    cpl_status,
    output logic                          cpl_valid,
    input  logic                          cpl_ready
`ifdef PSPIN_EGRESS_DMA_STATS_EN
   ,output logic [31:0]                   stat_pkts,
    output logic [31:0]                   stat_bytes,
    output logic [31:0]                   stat_errs
`endif
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH/8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {IDLE, AR, DATA, CPL} state_t;

    state_t                      state, state_next;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]        len_q;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic [7:0]                  total_q, rem_beats, burst_q, burst_cnt, frame_cnt;
    logic [1:0]                  status_q;
    logic                        err_q;

    logic                        desc_hs, ar_hs, beat_hs, desc_bad;
    logic                        burst_end, is_final;
    logic [LEN_WIDTH-1:0]        desc_beats_full;
    logic [12:0]                 page_beats;
    logic [7:0]                  burst_beats;
    logic [BEAT_SHIFT-1:0]       tail_bytes;
    logic [AXIS_IF_KEEP_WIDTH-1:0] keep_tail;

    assign desc_hs  = desc_valid && desc_ready;
    assign ar_hs    = m_axi_pspin_arvalid && m_axi_pspin_arready;
    assign beat_hs  = (state == DATA) && m_axi_pspin_rvalid && m_axis_nic_tx_tready;
    assign desc_bad = (desc_len == '0) || (desc_len > LEN_WIDTH'(EGRESS_DMA_MTU)) ||
                      (desc_addr[BEAT_SHIFT-1:0] != '0);

    // ceil(len / beat size); only meaningful for descriptors that pass the checks
    assign desc_beats_full = (desc_len + LEN_WIDTH'(BEAT_BYTES - 1)) >> BEAT_SHIFT;

    // beats left before the next 4 KiB boundary (address is beat aligned)
    assign page_beats  = (13'd4096 - {1'b0, addr_q[11:0]}) >> BEAT_SHIFT;
    assign burst_beats = ({5'd0, rem_beats} < page_beats) ? rem_beats : page_beats[7:0];

    assign burst_end  = (burst_cnt == burst_q - 8'd1);
    assign is_final   = (frame_cnt == total_q - 8'd1);
    assign tail_bytes = len_q[BEAT_SHIFT-1:0];

    always_comb begin
        keep_tail = '0;
        for (int i = 0; i < AXIS_IF_KEEP_WIDTH; i++) begin
            keep_tail[i] = (i < int'(tail_bytes));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            tag_q     <= '0;
            total_q   <= '0;
            rem_beats <= '0;
            burst_q   <= '0;
            burst_cnt <= '0;
            frame_cnt <= '0;
            status_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (desc_hs) begin
                addr_q    <= desc_addr;
                len_q     <= desc_len;
                tag_q     <= desc_tag;
                total_q   <= desc_bad ? 8'd0 : desc_beats_full[7:0];
                rem_beats <= desc_bad ? 8'd0 : desc_beats_full[7:0];
                frame_cnt <= '0;
                status_q  <= desc_bad ? 2'd1 : 2'd0;
                err_q     <= 1'b0;
            end
            if (ar_hs) begin
                addr_q    <= addr_q + (AXI_ADDR_WIDTH'(burst_beats) << BEAT_SHIFT);
                rem_beats <= rem_beats - burst_beats;
                burst_q   <= burst_beats;
                burst_cnt <= '0;
            end
            if (beat_hs) begin
                burst_cnt <= burst_cnt + 8'd1;
                frame_cnt <= frame_cnt + 8'd1;
                // data is still forwarded; the error only shows in the completion
                if (m_axi_pspin_rresp[1] || (m_axi_pspin_rlast != burst_end)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (desc_hs) state_next = desc_bad ? CPL : AR;
            AR:   if (m_axi_pspin_arready) state_next = DATA;
            DATA: if (beat_hs && burst_end) state_next = (rem_beats != '0) ? AR : CPL;
            CPL:  if (cpl_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready is forced low while reset is held, since the IDLE state is already present
    assign desc_ready = (state == IDLE) && !rst;

    assign m_axi_pspin_arid    = '0;
    assign m_axi_pspin_araddr  = addr_q;
    assign m_axi_pspin_arlen   = (rem_beats == '0) ? 8'd0 : burst_beats - 8'd1;
    assign m_axi_pspin_arsize  = 3'(BEAT_SHIFT);
    assign m_axi_pspin_arburst = 2'b01;
    assign m_axi_pspin_arlock  = 1'b0;
    assign m_axi_pspin_arcache = 4'd0;
    assign m_axi_pspin_arprot  = 3'd0;
    assign m_axi_pspin_arvalid = (state == AR);
    assign m_axi_pspin_rready  = (state == DATA) && m_axis_nic_tx_tready;

    assign m_axis_nic_tx_tdata  = m_axi_pspin_rdata;
    assign m_axis_nic_tx_tvalid = (state == DATA) && m_axi_pspin_rvalid;
    assign m_axis_nic_tx_tlast  = (state == DATA) && is_final;
    assign m_axis_nic_tx_tkeep  = (is_final && (tail_bytes != '0)) ? keep_tail : '1;

    assign cpl_valid  = (state == CPL);
    assign cpl_tag    = tag_q;
    assign cpl_status = err_q ? 2'd2 : status_q;

`ifdef PSPIN_EGRESS_DMA_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
            stat_errs  <= '0;
        end else if (cpl_valid && cpl_ready) begin
            if (cpl_status == 2'd0) begin
                stat_pkts  <= stat_pkts + 32'd1;
                stat_bytes <= stat_bytes + 32'(len_q);
            end else begin
                stat_errs  <= stat_errs + 32'd1;
            end
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{m_axi_pspin_rid, m_axi_pspin_rresp[0], desc_beats_full, len_q};

endmodule

// File: tb/tb_pspin_egress_dma.sv
module tb_pspin_egress_dma;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  desc_addr = '0;
    logic [31:0]  desc_len = '0;
    logic [63:0]  desc_tag = '0;
    logic         desc_valid = 1'b0;
    logic         desc_ready;
    logic [7:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid, arready;
    logic [7:0]   rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid, tready, tlast;
    logic [63:0]  cpl_tag;
    logic [1:0]   cpl_status;
    logic         cpl_valid;
    logic         cpl_ready = 1'b0;
`ifdef PSPIN_EGRESS_DMA_STATS_EN
    logic [31:0]  stat_pkts, stat_bytes, stat_errs;
`endif

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic slow = 1'b0;
    int err_at = -1;

    pspin_egress_dma dut (
        .clk(clk), .rst(rst),
        .desc_addr(desc_addr), .desc_len(desc_len), .desc_tag(desc_tag),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .m_axi_pspin_arid(arid), .m_axi_pspin_araddr(araddr), .m_axi_pspin_arlen(arlen),
        .m_axi_pspin_arsize(arsize), .m_axi_pspin_arburst(arburst), .m_axi_pspin_arlock(arlock),
        .m_axi_pspin_arcache(arcache), .m_axi_pspin_arprot(arprot),
        .m_axi_pspin_arvalid(arvalid), .m_axi_pspin_arready(arready),
        .m_axi_pspin_rid(rid), .m_axi_pspin_rdata(rdata), .m_axi_pspin_rresp(rresp),
        .m_axi_pspin_rlast(rlast), .m_axi_pspin_rvalid(rvalid), .m_axi_pspin_rready(rready),
        .m_axis_nic_tx_tdata(tdata), .m_axis_nic_tx_tkeep(tkeep), .m_axis_nic_tx_tvalid(tvalid),
        .m_axis_nic_tx_tready(tready), .m_axis_nic_tx_tlast(tlast),
        .cpl_tag(cpl_tag), .cpl_status(cpl_status), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready)
`ifdef PSPIN_EGRESS_DMA_STATS_EN
       ,.stat_pkts(stat_pkts), .stat_bytes(stat_bytes), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    // memory contents: each 32-bit word holds its own byte address
    function automatic logic [511:0] mem_word(input logic [31:0] a);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = a + 32'(k*4);
        return w;
    endfunction

    // AXI read slave: one outstanding burst
    logic        r_act;
    logic [31:0] r_addr;
    logic [8:0]  r_left;
    int          r_served;
    logic        tog;
    int          ar_cnt;
    logic [31:0] ar_addr_log [0:15];
    logic [7:0]  ar_len_log  [0:15];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act <= 1'b0; r_addr <= '0; r_left <= '0; r_served <= 0; tog <= 1'b0; ar_cnt <= 0;
        end else begin
            tog <= ~tog;
            if (arvalid && arready) begin
                r_act <= 1'b1;
                r_addr <= araddr;
                r_left <= {1'b0, arlen} + 9'd1;
                ar_addr_log[ar_cnt[3:0]] <= araddr;
                ar_len_log[ar_cnt[3:0]] <= arlen;
                ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) begin
                r_addr <= r_addr + 32'd64;
                r_left <= r_left - 9'd1;
                r_served <= r_served + 1;
                if (r_left == 9'd1) r_act <= 1'b0;
            end
        end
    end

    assign arready = slow ? tog : 1'b1;
    assign tready  = slow ? tog : 1'b1;
    assign rvalid  = r_act;
    assign rlast   = r_act && (r_left == 9'd1);
    assign rdata   = mem_word(r_addr);
    assign rresp   = (r_served == err_at) ? 2'b10 : 2'b00;
    assign rid     = '0;

    // stream / completion monitor, sampled mid-cycle
    int           beat_cnt = 0;
    int           cpl_cnt = 0;
    int           arv_cycles = 0;
    logic [511:0] mon_data [0:63];
    logic [63:0]  mon_keep [0:63];
    logic         mon_last [0:63];
    logic [63:0]  cpl_tag_log [0:15];
    logic [1:0]   cpl_stat_log [0:15];

    always @(negedge clk) begin
        if (tvalid && tready) begin
            mon_data[beat_cnt[5:0]] <= tdata;
            mon_keep[beat_cnt[5:0]] <= tkeep;
            mon_last[beat_cnt[5:0]] <= tlast;
            beat_cnt <= beat_cnt + 1;
        end
        if (cpl_valid && cpl_ready) begin
            cpl_tag_log[cpl_cnt[3:0]]  <= cpl_tag;
            cpl_stat_log[cpl_cnt[3:0]] <= cpl_status;
            cpl_cnt <= cpl_cnt + 1;
        end
        if (arvalid) arv_cycles <= arv_cycles + 1;
    end

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic run_desc(input logic [31:0] a, input logic [31:0] l, input logic [63:0] t,
                            input int hold);
        int n;
        @(posedge clk); #1;
        desc_addr = a; desc_len = l; desc_tag = t; desc_valid = 1'b1;
        n = 0;
        while (!desc_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("desc_ready_timeout", 0, 1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
        n = 0;
        while (!cpl_valid && n < 2000) begin
            if (n > 0) chk("desc_ready_busy", desc_ready, 0);
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) chk("cpl_timeout", 0, 1);
        for (int k = 0; k < hold; k++) begin
            chk("cpl_hold_valid", cpl_valid, 1);
            chk("cpl_hold_tag", cpl_tag, t);
            chk("cpl_hold_dready", desc_ready, 0);
            @(posedge clk); #1;
        end
        cpl_ready = 1'b1;
        @(posedge clk); #1;
        cpl_ready = 1'b0;
        chk("dready_after_cpl", desc_ready, 1);
    endtask

    task automatic chk_frame(input int b0, input int nb, input logic [31:0] a,
                             input logic [63:0] last_keep);
        chk("beat_count", beat_cnt - b0, nb);
        for (int i = 0; i < nb; i++) begin
            chk("beat_data", mon_data[(b0+i) % 64], mem_word(a + 32'(i*64)));
            chk("beat_keep", mon_keep[(b0+i) % 64], (i == nb-1) ? last_keep : 64'hFFFF_FFFF_FFFF_FFFF);
            chk("beat_last", mon_last[(b0+i) % 64], (i == nb-1));
        end
    endtask

    initial begin
        int b0, a0, c0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_desc_ready", desc_ready, 1);
        chk("idle_araddr", araddr, 0);
        chk("idle_arlen", arlen, 0);
        chk("idle_cpl_tag", cpl_tag, 0);
        chk("idle_cpl_status", cpl_status, 0);
        chk("arsize", arsize, 3'd6);
        chk("arburst", arburst, 2'b01);

        // 128 B, one burst of 2 beats
        b0 = beat_cnt; a0 = ar_cnt; c0 = cpl_cnt;
        run_desc(32'h1c10_0000, 32'd128, 64'h1111_0000_0000_0001, 0);
        chk("t1_ar_cnt", ar_cnt - a0, 1);
        chk("t1_araddr", ar_addr_log[a0], 32'h1c10_0000);
        chk("t1_arlen", ar_len_log[a0], 8'd1);
        chk_frame(b0, 2, 32'h1c10_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_cpl_tag", cpl_tag_log[c0], 64'h1111_0000_0000_0001);
        chk("t1_cpl_status", cpl_stat_log[c0], 2'd0);

        // MTU-sized packet, partial last beat of 28 bytes
        b0 = beat_cnt; a0 = ar_cnt; c0 = cpl_cnt;
        run_desc(32'h1c10_0000, 32'd1500, 64'h2222, 0);
        chk("t2_ar_cnt", ar_cnt - a0, 1);
        chk("t2_arlen", ar_len_log[a0], 8'd23);
        chk_frame(b0, 24, 32'h1c10_0000, 64'h0000_0000_0FFF_FFFF);
        chk("t2_cpl_status", cpl_stat_log[c0], 2'd0);

        // crosses a 4 KiB boundary after one beat
        b0 = beat_cnt; a0 = ar_cnt; c0 = cpl_cnt;
        run_desc(32'h1c10_0FC0, 32'd256, 64'h3333, 0);
        chk("t3_ar_cnt", ar_cnt - a0, 2);
        chk("t3_ar0_addr", ar_addr_log[a0], 32'h1c10_0FC0);
        chk("t3_ar0_len", ar_len_log[a0], 8'd0);
        chk("t3_ar1_addr", ar_addr_log[a0+1], 32'h1c10_1000);
        chk("t3_ar1_len", ar_len_log[a0+1], 8'd2);
        chk_frame(b0, 4, 32'h1c10_0FC0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_cpl_status", cpl_stat_log[c0], 2'd0);

        // bad descriptors: no AR, no beats
        b0 = beat_cnt; a0 = arv_cycles; c0 = cpl_cnt;
        run_desc(32'h1c10_0000, 32'd0, 64'h4440, 0);
        run_desc(32'h1c10_0000, 32'd1501, 64'h4441, 0);
        run_desc(32'h1c10_0004, 32'd64, 64'h4442, 0);
        chk("t4_arvalid_cycles", arv_cycles - a0, 0);
        chk("t4_beats", beat_cnt - b0, 0);
        chk("t4_cpl0_status", cpl_stat_log[c0], 2'd1);
        chk("t4_cpl1_status", cpl_stat_log[c0+1], 2'd1);
        chk("t4_cpl2_status", cpl_stat_log[c0+2], 2'd1);
        chk("t4_cpl2_tag", cpl_tag_log[c0+2], 64'h4442);

        // SLVERR on beat 2 of 4: data still streamed, status 2
        b0 = beat_cnt; c0 = cpl_cnt;
        err_at = r_served + 1;
        run_desc(32'h1c10_0000, 32'd256, 64'h5555, 0);
        err_at = -1;
        chk_frame(b0, 4, 32'h1c10_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_cpl_status", cpl_stat_log[c0], 2'd2);

        // backpressure on AR and stream, completion held off for 5 cycles
        b0 = beat_cnt; a0 = ar_cnt; c0 = cpl_cnt;
        slow = 1'b1;
        run_desc(32'h1c10_0F80, 32'd192, 64'h6666_7777_8888_9999, 5);
        slow = 1'b0;
        chk("t6_ar_cnt", ar_cnt - a0, 2);
        chk("t6_ar0_len", ar_len_log[a0], 8'd1);
        chk("t6_ar1_addr", ar_addr_log[a0+1], 32'h1c10_1000);
        chk("t6_ar1_len", ar_len_log[a0+1], 8'd0);
        chk_frame(b0, 3, 32'h1c10_0F80, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_cpl_tag", cpl_tag_log[c0], 64'h6666_7777_8888_9999);
        chk("t6_cpl_status", cpl_stat_log[c0], 2'd0);
        chk("t6_idle_rready", rready, 0);
        chk("t6_idle_tvalid", tvalid, 0);

`ifdef PSPIN_EGRESS_DMA_STATS_EN
        chk("stat_pkts", stat_pkts, 32'd4);
        chk("stat_bytes", stat_bytes, 32'd2076);
        chk("stat_errs", stat_errs, 32'd4);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
